// File: rtl/cache_types.sv
// Shared cache-side types: DFP adapter FSM states and line/beat widths.
package cache_types;
   typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEAT, WR_BEAT, RESP} dfp_adapter_state_t;
   localparam int DFP_LINE_BITS = 256;
   localparam int DFP_BEAT_BITS = 64;
endpackage

// File: rtl/dfp_burst_adapter.sv
// DFP line <-> 4-beat bmem burst responder; one line in flight, write ~6 cycles, read ~7.
// bmem stalls via bmem_ready (command/write beats) and rvalid gaps; L2 holds its request until dfp_resp.
module dfp_burst_adapter
   import cache_types::*;
#(
   parameter int LINE_BITS = DFP_LINE_BITS,
   parameter int BEAT_BITS = DFP_BEAT_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          dfp_addr,
   input  logic                 dfp_read,
   input  logic                 dfp_write,
   input  logic [LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic                 dfp_resp,
   output logic [31:0]          bmem_addr,
   output logic                 bmem_read,
   output logic                 bmem_write,
   output logic [BEAT_BITS-1:0] bmem_wdata,
   input  logic                 bmem_ready,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid,
   output logic                 protocol_err
);
   localparam int BEATS = LINE_BITS / BEAT_BITS;
   localparam int CW    = $clog2(BEATS);

   dfp_adapter_state_t   state_q;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_inc;
   logic [LINE_BITS-1:0] wdata_q;
   logic [LINE_BITS-1:0] rbuf_q;
   logic [31:0]          addr_q;
   logic [BEAT_BITS-1:0] wbeat_q;
   logic                 resp_q;
   logic                 read_q;
   logic                 write_q;
   logic                 err_q;
   logic                 last_beat;

   assign cnt_inc   = cnt_q + CW'(1);
   assign last_beat = (cnt_q == CW'(BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         addr_q  <= '0;
         wbeat_q <= '0;
         resp_q  <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (dfp_write) begin
                  // Write wins a simultaneous read; the collision is recorded until reset.
                  if (dfp_read) err_q <= 1'b1;
                  state_q <= WR_BEAT;
                  addr_q  <= dfp_addr & ~32'h1F;
                  wdata_q <= dfp_wdata;
                  wbeat_q <= dfp_wdata[BEAT_BITS-1:0];
                  write_q <= 1'b1;
               end else if (dfp_read) begin
                  state_q <= RD_CMD;
                  addr_q  <= dfp_addr & ~32'h1F;
                  read_q  <= 1'b1;
               end
            end
            RD_CMD: begin
               if (bmem_ready) begin
                  read_q  <= 1'b0;
                  state_q <= RD_BEAT;
               end
            end
            RD_BEAT: begin
               if (bmem_rvalid) begin
                  rbuf_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
                  cnt_q <= cnt_inc;
                  if (last_beat) begin
                     state_q <= RESP;
                     resp_q  <= 1'b1;
                  end
               end
            end
            WR_BEAT: begin
               if (bmem_ready) begin
                  cnt_q   <= cnt_inc;
                  wbeat_q <= wdata_q[int'(cnt_inc)*BEAT_BITS +: BEAT_BITS];
                  if (last_beat) begin
                     state_q <= RESP;
                     resp_q  <= 1'b1;
                     write_q <= 1'b0;
                     wbeat_q <= '0;
                  end
               end
            end
            RESP: begin
               resp_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dfp_rdata    = rbuf_q;
   assign dfp_resp     = resp_q;
   assign bmem_addr    = addr_q;
   assign bmem_read    = read_q;
   assign bmem_write   = write_q;
   assign bmem_wdata   = wbeat_q;
   assign protocol_err = err_q;
endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Directed bench for dfp_burst_adapter: inputs driven and outputs sampled on the falling edge.
module tb_dfp_burst_adapter;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  dfp_addr = '0;
   logic         dfp_read = 1'b0, dfp_write = 1'b0;
   logic [255:0] dfp_wdata = '0;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read, bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready = 1'b0;
   logic [63:0]  bmem_rdata = '0;
   logic         bmem_rvalid = 1'b0;
   logic         protocol_err;

   int checks = 0, errors = 0;

   // per-transaction observations recorded by run_txn
   int           resp_cnt, resp_cyc, rd_cmd_cyc, acc_cnt;
   logic [255:0] rdata_seen;
   logic [31:0]  addr_seen;
   logic [63:0]  acc [0:7];
   logic [63:0]  pres [0:31];
   bit           pres_v [0:31];
   logic [63:0]  rdv [0:31];

   always #5 clk = ~clk;

   dfp_burst_adapter dut (
      .clk(clk), .rst(rst), .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
      .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .bmem_addr(bmem_addr),
      .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
      .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
      .protocol_err(protocol_err)
   );

   task automatic fill_garbage();
      for (int i = 0; i < 32; i++) rdv[i] = 64'hEEEE_0000_0000_0000 | 64'(i);
   endtask

   // Request presented at cycle 0 and held until the cycle after dfp_resp.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd,
                          input bit tog, input logic [31:0] vmask, input int ncyc);
      resp_cnt = 0; resp_cyc = -1; rd_cmd_cyc = 0; acc_cnt = 0;
      rdata_seen = '0; addr_seen = '0;
      for (int n = 0; n < 32; n++) pres_v[n] = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         if (dfp_resp) begin resp_cnt++; resp_cyc = n; rdata_seen = dfp_rdata; end
         if (bmem_read) rd_cmd_cyc++;
         if (bmem_read || bmem_write) addr_seen = bmem_addr;
         if (bmem_write) begin pres[n] = bmem_wdata; pres_v[n] = 1'b1; end
         if (n == 0) begin
            dfp_read = rd; dfp_write = wr; dfp_addr = a; dfp_wdata = wd;
         end
         if (resp_cnt > 0 && n > resp_cyc) begin dfp_read = 1'b0; dfp_write = 1'b0; end
         bmem_ready  = tog ? (n % 2 == 1) : 1'b1;
         bmem_rvalid = vmask[n];
         bmem_rdata  = rdv[n];
         if (bmem_write && bmem_ready && acc_cnt < 8) begin acc[acc_cnt] = bmem_wdata; acc_cnt++; end
      end
      dfp_read = 1'b0; dfp_write = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata, protocol_err} !== '0) begin
         errors++; $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h err=%b, want all 0",
                            dfp_resp, bmem_read, bmem_write, bmem_addr, protocol_err);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_read_basic();
      logic [255:0] exp;
      exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      fill_garbage();
      rdv[2] = 64'h1111_1111_1111_1111; rdv[3] = 64'h2222_2222_2222_2222;
      rdv[4] = 64'h3333_3333_3333_3333; rdv[5] = 64'h4444_4444_4444_4444;
      run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0, 32'hFFFF_FFFF, 10);
      checks++; if (addr_seen !== 32'h0000_1220) begin errors++; $display("FAIL read_addr: got %h want 00001220", addr_seen); end
      checks++; if (rd_cmd_cyc !== 1) begin errors++; $display("FAIL read_cmd_cycles: got %0d want 1", rd_cmd_cyc); end
      checks++; if (resp_cyc !== 6) begin errors++; $display("FAIL read_resp_cycle: got %0d want 6", resp_cyc); end
      checks++; if (resp_cnt !== 1) begin errors++; $display("FAIL read_resp_count: got %0d want 1", resp_cnt); end
      checks++; if (rdata_seen !== exp) begin errors++; $display("FAIL read_rdata: got %h want %h", rdata_seen, exp); end
   endtask

   task automatic test_write_toggle();
      logic [63:0] beats [0:3];
      logic [255:0] exp_rd;
      int idx;
      beats[0] = 64'hAAAA_AAAA_AAAA_AAAA; beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      beats[2] = 64'hCCCC_CCCC_CCCC_CCCC; beats[3] = 64'hDDDD_DDDD_DDDD_DDDD;
      exp_rd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      run_txn(1'b0, 1'b1, 32'h8000_0047, {beats[3], beats[2], beats[1], beats[0]}, 1'b1, 32'h0, 14);
      idx = 0;
      for (int n = 1; n <= 8; n++) begin
         if (pres_v[n] && idx < 4) begin
            checks++;
            if (pres[n] !== beats[idx]) begin errors++; $display("FAIL write_beat_held c%0d: got %h want %h", n, pres[n], beats[idx]); end
            if (n % 2 == 1) idx++;
         end
      end
      checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL write_accept_count: got %0d want 4", acc_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc[i] !== beats[i]) begin errors++; $display("FAIL write_accept_beat%0d: got %h want %h", i, acc[i], beats[i]); end
      end
      checks++; if (addr_seen !== 32'h8000_0040) begin errors++; $display("FAIL write_addr: got %h want 80000040", addr_seen); end
      checks++; if (resp_cyc !== 8 || resp_cnt !== 1) begin errors++; $display("FAIL write_resp: got cyc %0d cnt %0d want 8/1", resp_cyc, resp_cnt); end
      checks++; if (rdata_seen !== exp_rd) begin errors++; $display("FAIL write_rdata_kept: got %h want %h", rdata_seen, exp_rd); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL write_no_err: got %b want 0", protocol_err); end
   endtask

   task automatic test_read_gaps();
      logic [255:0] exp;
      exp = {64'h0D0D_0000_0000_000D, 64'h0C0C_0000_0000_000C, 64'h0B0B_0000_0000_000B, 64'h0A0A_0000_0000_000A};
      fill_garbage();
      rdv[3] = 64'h0A0A_0000_0000_000A; rdv[7]  = 64'h0B0B_0000_0000_000B;
      rdv[8] = 64'h0C0C_0000_0000_000C; rdv[12] = 64'h0D0D_0000_0000_000D;
      // rvalid also pulsed in IDLE (c0) and RD_CMD (c1); those must be ignored
      run_txn(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, 32'h0000_118B, 18);
      checks++; if (resp_cyc !== 13) begin errors++; $display("FAIL gaps_resp_cycle: got %0d want 13", resp_cyc); end
      checks++; if (resp_cnt !== 1) begin errors++; $display("FAIL gaps_resp_count: got %0d want 1", resp_cnt); end
      checks++; if (rdata_seen !== exp) begin errors++; $display("FAIL gaps_rdata: got %h want %h", rdata_seen, exp); end
   endtask

   task automatic test_both_high();
      run_txn(1'b1, 1'b1, 32'h0000_2000, {4{64'h5A5A_5A5A_5A5A_5A5A}}, 1'b0, 32'h0, 10);
      checks++; if (rd_cmd_cyc !== 0 || acc_cnt !== 4) begin errors++; $display("FAIL both_write_wins: got rdcmd %0d acc %0d want 0/4", rd_cmd_cyc, acc_cnt); end
      checks++; if (resp_cyc !== 5) begin errors++; $display("FAIL both_resp_cycle: got %0d want 5", resp_cyc); end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL both_err_set: got %b want 1", protocol_err); end
   endtask

   task automatic test_back_to_back();
      fill_garbage();
      rdv[2] = 64'h1; rdv[3] = 64'h2; rdv[4] = 64'h3; rdv[5] = 64'h4;
      run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 1'b0, 32'hFFFF_FFFF, 8);
      checks++; if (resp_cnt !== 1 || resp_cyc !== 6 || rd_cmd_cyc !== 1) begin errors++;
         $display("FAIL b2b_read: got cnt %0d cyc %0d rdcmd %0d want 1/6/1", resp_cnt, resp_cyc, rd_cmd_cyc); end
      checks++; if (rdata_seen !== {64'h4, 64'h3, 64'h2, 64'h1}) begin errors++; $display("FAIL b2b_read_data: got %h", rdata_seen); end
      run_txn(1'b0, 1'b1, 32'h0000_3020, {64'h8, 64'h7, 64'h6, 64'h5}, 1'b0, 32'h0, 14);
      checks++; if (resp_cnt !== 1 || resp_cyc !== 5 || rd_cmd_cyc !== 0 || acc_cnt !== 4) begin errors++;
         $display("FAIL b2b_write: got cnt %0d cyc %0d rdcmd %0d acc %0d want 1/5/0/4", resp_cnt, resp_cyc, rd_cmd_cyc, acc_cnt); end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky: got %b want 1", protocol_err); end
   endtask

   task automatic test_reset_mid_burst();
      int extra;
      fill_garbage();
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (n == 0) begin dfp_read = 1'b1; dfp_addr = 32'h0000_4000; end
         bmem_ready = 1'b1; bmem_rvalid = 1'b1; bmem_rdata = 64'hF0F0_0000_0000_0000 | 64'(n);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata, protocol_err} !== '0) begin
         errors++; $display("FAIL midrst_outputs: got rdata=%h addr=%h err=%b want all 0", dfp_rdata, bmem_addr, protocol_err);
      end
      @(negedge clk); dfp_read = 1'b0; bmem_rvalid = 1'b0; rst = 1'b0;
      extra = 0;
      for (int n = 0; n < 8; n++) begin @(negedge clk); if (dfp_resp) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_no_resp: got %0d resp want 0", extra); end
      rdv[2] = 64'h21; rdv[3] = 64'h22; rdv[4] = 64'h23; rdv[5] = 64'h24;
      run_txn(1'b1, 1'b0, 32'h0000_4000, '0, 1'b0, 32'hFFFF_FFFF, 9);
      checks++; if (resp_cnt !== 1 || resp_cyc !== 6) begin errors++; $display("FAIL midrst_recover: got cnt %0d cyc %0d want 1/6", resp_cnt, resp_cyc); end
      checks++; if (rdata_seen !== {64'h24, 64'h23, 64'h22, 64'h21}) begin errors++; $display("FAIL midrst_recover_data: got %h", rdata_seen); end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_toggle();
      test_read_gaps();
      test_both_high();
      test_back_to_back();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
